// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 1-cycle-latency RAM port between two
// requesters. It uses round-robin arbitration, with an optional lock that
// keeps ownership across back-to-back bursts. Read data is returned to the
// requester that issued the read, together with a one-cycle rvalid pulse.
module ram_port_arbiter #(
  parameter int DATA  = 4,
  parameter int DEPTH = 16,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_0,
  input  logic            we_0,
  input  logic            lock_0,
  input  logic [ADDR-1:0] addr_0,
  input  logic [DATA-1:0] wdata_0,
  output logic            ack_0,
  output logic            rvalid_0,
  output logic [DATA-1:0] rdata_0,
  input  logic            req_1,
  input  logic            we_1,
  input  logic            lock_1,
  input  logic [ADDR-1:0] addr_1,
  input  logic [DATA-1:0] wdata_1,
  output logic            ack_1,
  output logic            rvalid_1,
  output logic [DATA-1:0] rdata_1,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED_0, LOCKED_1} lock_t;

  lock_t           lock_st;
  logic            last_grant;
  logic [1:0]      rd_vld_p1;
  logic [DATA-1:0] rdata_hold_0;
  logic [DATA-1:0] rdata_hold_1;
  logic            gnt_0;
  logic            gnt_1;

  // Grant selection: a lock restricts the grant to its owner. Otherwise, a tie goes to the requester that was not served last.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!rst) begin
      case (lock_st)
        UNLOCKED: begin
          if (req_0 && req_1) begin
            gnt_0 = last_grant;
            gnt_1 = ~last_grant;
          end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
          end
        end
        LOCKED_0: gnt_0 = req_0;
        LOCKED_1: gnt_1 = req_1;
        default: begin
          gnt_0 = 1'b0;
          gnt_1 = 1'b0;
        end
      endcase
    end
  end

  assign ack_0 = gnt_0;
  assign ack_1 = gnt_1;

  // Stage p0: drive the RAM port from the winner. An idle port is all zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_0) begin
      mem_we    = we_0;
      mem_addr  = addr_0;
      mem_wdata = wdata_0;
    end else if (gnt_1) begin
      mem_we    = we_1;
      mem_addr  = addr_1;
      mem_wdata = wdata_1;
    end
  end

  // Arbitration history and lock ownership, updated on each issue or when a lock owner drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      lock_st    <= UNLOCKED;
    end else begin
      if (gnt_0)
        last_grant <= 1'b0;
      else if (gnt_1)
        last_grant <= 1'b1;
      case (lock_st)
        UNLOCKED: begin
          if (gnt_0 && lock_0)
            lock_st <= LOCKED_0;
          else if (gnt_1 && lock_1)
            lock_st <= LOCKED_1;
        end
        LOCKED_0: if (!req_0 || (gnt_0 && !lock_0)) lock_st <= UNLOCKED;
        LOCKED_1: if (!req_1 || (gnt_1 && !lock_1)) lock_st <= UNLOCKED;
        default:  lock_st <= UNLOCKED;
      endcase
    end
  end

  // Stage p1: track which requester owns the RAM's registered read data, and keep the last returned word per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1    <= 2'b00;
      rdata_hold_0 <= '0;
      rdata_hold_1 <= '0;
    end else begin
      rd_vld_p1 <= {gnt_1 & ~we_1, gnt_0 & ~we_0};
      if (rd_vld_p1[0])
        rdata_hold_0 <= mem_rdata;
      if (rd_vld_p1[1])
        rdata_hold_1 <= mem_rdata;
    end
  end

  assign rvalid_0 = rd_vld_p1[0];
  assign rvalid_1 = rd_vld_p1[1];
  assign rdata_0  = rd_vld_p1[0] ? mem_rdata : rdata_hold_0;
  assign rdata_1  = rd_vld_p1[1] ? mem_rdata : rdata_hold_1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a read-first registered RAM behind the arbiter,
// directed scenarios, then random two-requester traffic checked against a
// cycle-level reference model of ownership, fairness and memory contents.
module tb_ram_port_arbiter;
  localparam int DATA  = 4;
  localparam int DEPTH = 16;
  localparam int ADDR  = 4;

  logic clk = 1'b0;
  logic rst;
  logic req_0, we_0, lock_0, req_1, we_1, lock_1;
  logic [ADDR-1:0] addr_0, addr_1, mem_addr;
  logic [DATA-1:0] wdata_0, wdata_1, mem_wdata, mem_rdata;
  logic ack_0, ack_1, rvalid_0, rvalid_1, mem_we;
  logic [DATA-1:0] rdata_0, rdata_1;

  logic [DATA-1:0] ram [DEPTH];

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  logic [DATA-1:0] smem [DEPTH];
  int owner;
  int prefer;
  bit erv [2];
  logic [DATA-1:0] edat [2];
  logic [DATA-1:0] hold [2];

  // snapshot of DUT outputs from the last step
  int s_ack0, s_ack1, s_we, s_addr, s_rv0, s_rv1, s_rd0, s_rd1;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA(DATA), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .ack_0(ack_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ack_1(ack_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // read-first RAM with registered output
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we)
      ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    prefer = 0;
    for (int i = 0; i < 2; i++) begin
      erv[i]  = 1'b0;
      edat[i] = '0;
      hold[i] = '0;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, and return just after the rising edge.
  task automatic step(output int w);
    bit rq [2];
    bit wv [2];
    bit lk [2];
    logic [ADDR-1:0] ad [2];
    logic [DATA-1:0] wd [2];
    int i;
    @(negedge clk);
    rq[0] = req_0; rq[1] = req_1;
    wv[0] = we_0;  wv[1] = we_1;
    lk[0] = lock_0; lk[1] = lock_1;
    ad[0] = addr_0; ad[1] = addr_1;
    wd[0] = wdata_0; wd[1] = wdata_1;
    w = -1;
    if (owner >= 0) begin
      if (rq[owner]) w = owner;
    end else if (rq[0] && rq[1]) w = prefer;
    else if (rq[0]) w = 0;
    else if (rq[1]) w = 1;
    i = (w < 0) ? 0 : w;

    s_ack0 = int'(ack_0);  s_ack1 = int'(ack_1);
    s_we   = int'(mem_we); s_addr = int'(mem_addr);
    s_rv0  = int'(rvalid_0); s_rv1 = int'(rvalid_1);
    s_rd0  = int'(rdata_0);  s_rd1 = int'(rdata_1);
    chk("ack_0", s_ack0, (w == 0) ? 1 : 0);
    chk("ack_1", s_ack1, (w == 1) ? 1 : 0);
    chk("mem_we", s_we, (w < 0) ? 0 : int'(wv[i]));
    chk("mem_addr", s_addr, (w < 0) ? 0 : int'(ad[i]));
    chk("mem_wdata", int'(mem_wdata), (w < 0) ? 0 : int'(wd[i]));
    chk("rvalid_0", s_rv0, int'(erv[0]));
    chk("rvalid_1", s_rv1, int'(erv[1]));
    chk("rdata_0", s_rd0, int'(erv[0] ? edat[0] : hold[0]));
    chk("rdata_1", s_rd1, int'(erv[1] ? edat[1] : hold[1]));

    for (int k = 0; k < 2; k++) begin
      if (erv[k]) hold[k] = edat[k];
      erv[k] = 1'b0;
    end
    if (w >= 0) begin
      if (wv[w]) smem[ad[w]] = wd[w];
      else begin
        erv[w]  = 1'b1;
        edat[w] = smem[ad[w]];
      end
      prefer = 1 - w;
      if (owner < 0 && lk[w]) owner = w;
      else if (owner == w && !lk[w]) owner = -1;
    end
    if (owner >= 0 && !rq[owner]) owner = -1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bit p0, p1;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]  <= DATA'(i * 7 + 3);
      smem[i] = DATA'(i * 7 + 3);
    end
    model_reset();
    rst = 1'b1;
    req_0 = 1'b1; we_0 = 1'b1; lock_0 = 1'b0; addr_0 = 4'd5; wdata_0 = 4'hF;
    req_1 = 1'b1; we_1 = 1'b0; lock_1 = 1'b0; addr_1 = 4'd6; wdata_1 = 4'h0;
    #1;
    chk("rst_ack0", int'(ack_0), 0);
    chk("rst_ack1", int'(ack_1), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_rvalid", int'(rvalid_0 | rvalid_1), 0);
    chk("rst_rdata", int'(rdata_0 | rdata_1), 0);
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single requester: write A to addr 3, read it back
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd3; wdata_0 = 4'hA;
    step(w);
    chk("sr_wr_ack", s_ack0, 1);
    chk("sr_wr_we", s_we, 1);
    chk("sr_wr_addr", s_addr, 3);
    we_0 = 1'b0;
    step(w);
    req_0 = 1'b0;
    step(w);
    chk("sr_rvalid", s_rv0, 1);
    chk("sr_rdata", s_rd0, 'hA);
    step(w);
    chk("sr_rvalid_off", s_rv0, 0);
    chk("sr_hold", s_rd0, 'hA);

    // reset while an R0 read is in flight and R0 holds a lock
    req_0 = 1'b1; we_0 = 1'b0; lock_0 = 1'b1; addr_0 = 4'd4;
    step(w);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_rvalid", int'(rvalid_0), 0);
    chk("mr_rdata", int'(rdata_0), 0);
    chk("mr_ack", int'(ack_0), 0);
    chk("mr_addr", int'(mem_addr), 0);
    req_0 = 1'b0; lock_0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // contention: both read continuously, grants must alternate from R0
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd1;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd2; lock_1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(w);
      chk("ct_ack0", s_ack0, (k % 2 == 0) ? 1 : 0);
      chk("ct_ack1", s_ack1, (k % 2 == 1) ? 1 : 0);
    end
    req_0 = 1'b0; req_1 = 1'b0;
    step(w);

    // R0 serviced last, so R1 takes the first contended cycle of its burst
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd9; wdata_0 = 4'h6;
    step(w);
    we_0 = 1'b0; addr_0 = 4'd5;
    req_1 = 1'b1; we_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_1 = ADDR'(5 + k); wdata_1 = DATA'($urandom); lock_1 = (k < 2);
      step(w);
      chk("lb_ack1", s_ack1, 1);
      chk("lb_ack0", s_ack0, 0);
    end
    req_1 = 1'b0; lock_1 = 1'b0;
    step(w);
    chk("lb_r0_after", s_ack0, 1);

    // abandoned lock: R0 locks, then drops its request while R1 waits
    lock_0 = 1'b1; addr_0 = 4'd6;
    step(w);
    chk("ab_ack0", s_ack0, 1);
    req_0 = 1'b0; lock_0 = 1'b0;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd7;
    step(w);
    chk("ab_blocked", s_ack1, 0);
    step(w);
    chk("ab_ack1", s_ack1, 1);
    req_1 = 1'b0;
    step(w);

    // idle: stale fields on the request lines must not reach the RAM
    we_0 = 1'b1; addr_0 = 4'd3;
    for (int k = 0; k < 5; k++) begin
      step(w);
      chk("id_we", s_we, 0);
      chk("id_addr", s_addr, 0);
      chk("id_ack", s_ack0 | s_ack1, 0);
      chk("id_rvalid", s_rv0 | s_rv1, 0);
    end

    // random traffic under the hold-until-ack protocol
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1;
        we_0 = 1'($urandom); lock_0 = ($urandom_range(0, 2) == 0);
        addr_0 = ADDR'($urandom); wdata_0 = DATA'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1;
        we_1 = 1'($urandom); lock_1 = ($urandom_range(0, 2) == 0);
        addr_1 = ADDR'($urandom); wdata_1 = DATA'($urandom);
      end
      req_0 = p0; req_1 = p1;
      step(w);
      if (w == 0) p0 = 1'b0;
      if (w == 1) p1 = 1'b0;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    step(w);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
